// File: rtl/cios_pkg.sv
// cios_pkg: shared definitions for the CIOS Montgomery datapath blocks.
//   alpha_state_t : sequencer states of the multiply-accumulate stage.
//   word_t/dword_t: single/double word types at the default word width.
//   ALPHA_LATENCY : start-to-done cycle count at the default size.
//   alpha_latency : the same count for an arbitrary word count s.
package cios_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } alpha_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_S     = 8;

  typedef logic [DEF_WIDTH-1:0]   word_t;
  typedef logic [2*DEF_WIDTH-1:0] dword_t;

  // One capture edge, one LOAD edge, S MAC edges and one FINAL edge.
  localparam int ALPHA_LATENCY = DEF_S + 3;

  function automatic int alpha_latency(input int s);
    return s + 3;
  endfunction

endpackage

// File: rtl/mac_word.sv
// mac_word: combinational word multiply-accumulate {carry, sum} = t + a*b + c.
//   t_word, a_word, b_word, c_word : WIDTH-bit operands
//   sum   : low WIDTH bits of the result
//   carry : high WIDTH bits of the result (next word's carry)
// The 2*WIDTH-bit result cannot overflow: (2^W-1)^2 + 2(2^W-1) = 2^2W - 1.
module mac_word
  import cios_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] t_word,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic [WIDTH-1:0] c_word,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [2*WIDTH-1:0] acc;

  always_comb begin
    acc = ({{WIDTH{1'b0}}, a_word} * {{WIDTH{1'b0}}, b_word})
        + {{WIDTH{1'b0}}, t_word}
        + {{WIDTH{1'b0}}, c_word};
  end

  assign sum   = acc[WIDTH-1:0];
  assign carry = acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alpha_block.sv
// alpha_block: word-serial multiply-accumulate T <- T + a * b_i for one CIOS
// outer iteration, feeding the reduction stage of the same iteration.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear to IDLE (wins over start)
//   start      : begin an iteration, sampled only in IDLE or DONE
//   a          : S multiplicand words, a[0] in the low WIDTH bits
//   b_i        : multiplier word
//   T_in       : S+2 accumulator words from the previous iteration
//   busy       : high in LOAD/MAC/FINAL
//   done       : high in DONE; T_out is valid only then
//   T_out      : internal accumulator words, driven continuously
module alpha_block
  import cios_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int S     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     start,
  input  logic [WIDTH*S-1:0]       a,
  input  logic [WIDTH-1:0]         b_i,
  input  logic [WIDTH*(S+2)-1:0]   T_in,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*(S+2)-1:0]   T_out
);

  localparam int            JW     = $clog2(S) + 1;
  localparam logic [JW-1:0] J_LAST = JW'(S - 1);

  alpha_state_t     state_q, state_d;
  logic [WIDTH-1:0] t_q [S+2];
  logic [WIDTH-1:0] t_d [S+2];
  logic [WIDTH-1:0] a_q [S];
  logic [WIDTH-1:0] a_d [S];
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [JW-1:0]    j_q, j_d;

  logic [WIDTH-1:0] t_sel, a_sel;
  logic [WIDTH-1:0] mac_sum, mac_carry;
  logic [WIDTH:0]   fin_sum;

  // Word select for the current MAC index; compare-based so j never has to
  // match the array's index width.
  always_comb begin
    t_sel = '0;
    a_sel = '0;
    for (int k = 0; k < S; k++) begin
      if (j_q == JW'(k)) begin
        t_sel = t_q[k];
        a_sel = a_q[k];
      end
    end
  end

  mac_word #(.WIDTH(WIDTH)) u_mac (
    .t_word (t_sel),
    .a_word (a_sel),
    .b_word (b_q),
    .c_word (c_q),
    .sum    (mac_sum),
    .carry  (mac_carry)
  );

  assign fin_sum = {1'b0, t_q[S]} + {1'b0, c_q};

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    j_d     = j_q;
    if (flush) begin
      state_d = ST_IDLE;
      t_d     = '{default: '0};
      a_d     = '{default: '0};
      b_d     = '0;
      c_d     = '0;
      j_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            for (int k = 0; k < S + 2; k++) t_d[k] = T_in[k*WIDTH +: WIDTH];
            for (int k = 0; k < S; k++)     a_d[k] = a[k*WIDTH +: WIDTH];
            b_d     = b_i;
            c_d     = '0;
            j_d     = '0;
            state_d = ST_LOAD;
          end
        end
        // LOAD only registers the operands so the multiplier never sees
        // the input ports directly.
        ST_LOAD: state_d = ST_MAC;
        ST_MAC: begin
          for (int k = 0; k < S; k++) begin
            if (j_q == JW'(k)) t_d[k] = mac_sum;
          end
          c_d = mac_carry;
          j_d = j_q + JW'(1);
          if (j_q == J_LAST) state_d = ST_FINAL;
        end
        // Top word is overwritten with the final carry, not accumulated.
        ST_FINAL: begin
          t_d[S]   = fin_sum[WIDTH-1:0];
          t_d[S+1] = {{(WIDTH-1){1'b0}}, fin_sum[WIDTH]};
          state_d  = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      t_q     <= '{default: '0};
      a_q     <= '{default: '0};
      b_q     <= '0;
      c_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      j_q     <= j_d;
    end
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_MAC) || (state_q == ST_FINAL);
  assign done = (state_q == ST_DONE);

  for (genvar g = 0; g < S + 2; g++) begin : g_tout
    assign T_out[g*WIDTH +: WIDTH] = t_q[g];
  end

endmodule
